// File: rtl/scoreboard_pkg.sv
// Shared types, segment codes and BCD helpers for the two-digit scoreboard.
package scoreboard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_UPD      = 2'd1,
      ST_WAIT_REL = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_UP   = 2'd1,
      CMD_DOWN = 2'd2,
      CMD_CLR  = 2'd3
   } cmd_e;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic       wrap;
   } bcd_res_t;

   // One BCD step up or down; at the 99/00 boundary either wrap or hold.
   function automatic bcd_res_t bcd_step(input logic [3:0] tens, input logic [3:0] ones,
                                         input logic up, input logic wrap_en);
      bcd_res_t res;
      res.tens = tens;
      res.ones = ones;
      res.wrap = 1'b0;
      if (up) begin
         if (ones != 4'd9) begin
            res.ones = ones + 4'd1;
         end else if (tens != 4'd9) begin
            res.ones = 4'd0;
            res.tens = tens + 4'd1;
         end else if (wrap_en) begin
            res.ones = 4'd0;
            res.tens = 4'd0;
            res.wrap = 1'b1;
         end else begin
            res.wrap = 1'b0;
         end
      end else begin
         if (ones != 4'd0) begin
            res.ones = ones - 4'd1;
         end else if (tens != 4'd0) begin
            res.ones = 4'd9;
            res.tens = tens - 4'd1;
         end else if (wrap_en) begin
            res.ones = 4'd9;
            res.tens = 4'd9;
            res.wrap = 1'b1;
         end else begin
            res.wrap = 1'b0;
         end
      end
      return res;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/scoreboard_ctrl_btn_debounce.sv
// Button conditioning: 2-FF synchroniser, level debouncer and press pulse.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic             sync1_r;
   logic             sync2_r;
   logic             level_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;

   // Synchronise, count disagreeing samples and flip the accepted level once the run is long enough.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         level_r <= 1'b0;
         press_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
      end else begin
         sync1_r <= i_btn;
         sync2_r <= sync1_r;
         press_r <= 1'b0;
         if (sync2_r == level_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r == CNT_MAX) begin
            level_r <= sync2_r;
            press_r <= sync2_r;
            cnt_r   <= CNT_ZERO;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign o_level = level_r;
   assign o_press = press_r;

endmodule

// File: rtl/scoreboard_ctrl.sv
// Two-digit BCD up/down scoreboard: button command FSM, score register and display scan.
module scoreboard_ctrl
   import scoreboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int SCAN_CYCLES     = 4,
   parameter int WRAP            = 1
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_btn_up,
   input  logic       i_btn_down,
   input  logic       i_btn_clr,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones,
   output logic [6:0] o_seg,
   output logic [1:0] o_an,
   output logic       o_wrap
);

   localparam logic WRAP_EN = (WRAP != 0);
   localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);
   localparam logic [SCAN_W-1:0] SCAN_ZERO = SCAN_W'(0);

   logic level_up_s, level_down_s, level_clr_s;
   logic press_up_s, press_down_s, press_clr_s;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_up),
      .o_level(level_up_s), .o_press(press_up_s)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_down),
      .o_level(level_down_s), .o_press(press_down_s)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_clr),
      .o_level(level_clr_s), .o_press(press_clr_s)
   );

   state_e            state_r, state_nxt_s;
   cmd_e              cmd_s;
   logic              upd_s;
   bcd_res_t          step_s;
   logic [3:0]        tens_r, ones_r;
   logic              wrap_r;
   logic              sel_r;
   logic [SCAN_W-1:0] scan_cnt_r;

   // Command FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state, command priority and BCD step; the score is written on the edge entering UPD.
   always_comb begin
      state_nxt_s = state_r;
      cmd_s       = CMD_NONE;
      upd_s       = 1'b0;
      if (press_clr_s) begin
         cmd_s = CMD_CLR;
      end else if (press_up_s && !press_down_s) begin
         cmd_s = CMD_UP;
      end else if (press_down_s && !press_up_s) begin
         cmd_s = CMD_DOWN;
      end else begin
         cmd_s = CMD_NONE;
      end
      case (state_r)
         ST_IDLE: begin
            if (press_up_s || press_down_s || press_clr_s) begin
               state_nxt_s = ST_UPD;
               upd_s       = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_UPD: state_nxt_s = ST_WAIT_REL;
         ST_WAIT_REL: begin
            if (!level_up_s && !level_down_s && !level_clr_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_REL;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
      step_s = bcd_step(tens_r, ones_r, (cmd_s == CMD_UP), WRAP_EN);
   end

   // Score register and one-cycle wrap flag.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         tens_r <= 4'd0;
         ones_r <= 4'd0;
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= 1'b0;
         if (upd_s) begin
            case (cmd_s)
               CMD_CLR: begin
                  tens_r <= 4'd0;
                  ones_r <= 4'd0;
               end
               CMD_UP, CMD_DOWN: begin
                  tens_r <= step_s.tens;
                  ones_r <= step_s.ones;
                  wrap_r <= step_s.wrap;
               end
               default: begin
                  tens_r <= tens_r;
                  ones_r <= ones_r;
               end
            endcase
         end else begin
            tens_r <= tens_r;
            ones_r <= ones_r;
         end
      end
   end

   // Free-running digit scan, independent of button activity.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         scan_cnt_r <= SCAN_ZERO;
         sel_r      <= 1'b0;
      end else if (scan_cnt_r == SCAN_LAST) begin
         scan_cnt_r <= SCAN_ZERO;
         sel_r      <= ~sel_r;
      end else begin
         scan_cnt_r <= scan_cnt_r + SCAN_ONE;
      end
   end

   // Segment mux follows the live score so an update shows in the same cycle.
   always_comb begin
      if (sel_r) begin
         o_an  = 2'b01;
         o_seg = seg_decode(tens_r);
      end else begin
         o_an  = 2'b10;
         o_seg = seg_decode(ones_r);
      end
   end

   assign o_tens = tens_r;
   assign o_ones = ones_r;
   assign o_wrap = wrap_r;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed and randomized bench for scoreboard_ctrl; a WRAP=1 and a WRAP=0 instance share stimulus.
module tb_scoreboard_ctrl;

   localparam int D  = 16;
   localparam int SC = 4;

   logic clk = 1'b0, rst_n = 1'b0, up = 1'b0, dn = 1'b0, clr = 1'b0;
   logic [3:0] tens_w, ones_w, tens_n, ones_n;
   logic [6:0] seg_w, seg_n;
   logic [1:0] an_w, an_n;
   logic       wrap_w, wrap_n;

   int errors = 0, checks = 0;
   int exp_w = 0, exp_n = 0;
   bit ew_w = 1'b0, ew_n = 1'b0;
   int n_edges = 0;
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   scoreboard_ctrl dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn_up(up), .i_btn_down(dn), .i_btn_clr(clr),
      .o_tens(tens_w), .o_ones(ones_w), .o_seg(seg_w), .o_an(an_w), .o_wrap(wrap_w)
   );
   scoreboard_ctrl #(.WRAP(0)) dut_nw (
      .i_clk(clk), .i_rst_n(rst_n), .i_btn_up(up), .i_btn_down(dn), .i_btn_clr(clr),
      .o_tens(tens_n), .o_ones(ones_n), .o_seg(seg_n), .o_an(an_n), .o_wrap(wrap_n)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) n_edges <= 0;
      else        n_edges <= n_edges + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string nm, input int score, input bit wrp, input logic [3:0] t,
                            input logic [3:0] o, input logic [6:0] s, input logic [1:0] a, input logic w);
      int sel;
      sel = (n_edges / SC) % 2;
      chk({nm, ".tens"}, 32'(t), score / 10);
      chk({nm, ".ones"}, 32'(o), score % 10);
      chk({nm, ".wrap"}, 32'(w), 32'(wrp));
      chk({nm, ".an"},   32'(a), (sel == 1) ? 32'h1 : 32'h2);
      chk({nm, ".seg"},  32'(s), 32'(seg_tab[(sel == 1) ? score / 10 : score % 10]));
   endtask

   task automatic check_all();
      check_dut("w",  exp_w, ew_w, tens_w, ones_w, seg_w, an_w, wrap_w);
      check_dut("nw", exp_n, ew_n, tens_n, ones_n, seg_n, an_n, wrap_n);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   // Score arithmetic of the reference model.
   task automatic apply(input bit u, input bit d, input bit c);
      ew_w = 1'b0;
      ew_n = 1'b0;
      if (c) begin
         exp_w = 0;
         exp_n = 0;
      end else if (u && !d) begin
         if (exp_w == 99) begin exp_w = 0; ew_w = 1'b1; end
         else exp_w = exp_w + 1;
         if (exp_n < 99) exp_n = exp_n + 1;
      end else if (d && !u) begin
         if (exp_w == 0) begin exp_w = 99; ew_w = 1'b1; end
         else exp_w = exp_w - 1;
         if (exp_n > 0) exp_n = exp_n - 1;
      end
   endtask

   // Buttons already driven; next posedge is edge 0. Score changes at edge D+3.
   task automatic wait_update(input bit u, input bit d, input bit c, input int hold);
      repeat (D + 3) step();
      apply(u, d, c);
      step();
      ew_w = 1'b0;
      ew_n = 1'b0;
      step();
      repeat (hold - (D + 5)) step();
      up = 1'b0; dn = 1'b0; clr = 1'b0;
      repeat (D + 6) step();
   endtask

   task automatic press(input bit u, input bit d, input bit c, input int hold);
      up = u; dn = d; clr = c;
      wait_update(u, d, c, hold);
   endtask

   task automatic bounce(input bit on_up, input int per, input int toggles);
      for (int k = 0; k < toggles; k++) begin
         if (on_up) up = ~up;
         else       dn = ~dn;
         repeat (per) step();
      end
      up = 1'b0; dn = 1'b0;
      repeat (D + 6) step();
   endtask

   initial begin
      int op, hold;
      #2;
      check_all();
      chk("rst_seg", 32'(seg_w), 32'h40);
      chk("rst_an",  32'(an_w),  32'h2);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) step();

      // Held up press gives one step; a second press another.
      press(1'b1, 1'b0, 1'b0, 40);
      press(1'b1, 1'b0, 1'b0, D + 6);

      // Bounce shorter than the debounce window is ignored.
      bounce(1'b0, 5, 12);

      repeat (43) press(1'b1, 1'b0, 1'b0, D + 6);

      // Up and down together: no-op, then a re-press while up is held is discarded.
      up = 1'b1; dn = 1'b1;
      repeat (D + 3) step();
      apply(1'b1, 1'b1, 1'b0);
      repeat (6) step();
      dn = 1'b0;
      repeat (D + 6) step();
      dn = 1'b1;
      repeat (D + 8) step();
      up = 1'b0; dn = 1'b0;
      repeat (D + 6) step();
      chk("ud_hold", 32'(tens_w * 10 + ones_w), 32'd45);

      press(1'b1, 1'b0, 1'b1, D + 6);
      repeat (99) press(1'b1, 1'b0, 1'b0, D + 6);
      press(1'b1, 1'b0, 1'b0, D + 6);
      press(1'b0, 1'b0, 1'b1, D + 6);
      press(1'b0, 1'b1, 1'b0, D + 6);

      // Show 37 on both digits.
      press(1'b0, 1'b0, 1'b1, D + 6);
      repeat (37) press(1'b1, 1'b0, 1'b0, D + 6);
      for (int k = 0; k < 8; k++) begin
         step();
         if (an_w == 2'b10) chk("seg37_ones", 32'(seg_w), 32'h78);
         else               chk("seg37_tens", 32'(seg_w), 32'h30);
      end

      // Asynchronous reset while waiting for release; held button needs a full debounce afterwards.
      up = 1'b1;
      repeat (D + 3) step();
      apply(1'b1, 1'b0, 1'b0);
      step();
      ew_w = 1'b0; ew_n = 1'b0;
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      exp_w = 0; exp_n = 0;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      wait_update(1'b1, 1'b0, 1'b0, D + 8);

      for (int i = 0; i < 30; i++) begin
         op   = $urandom_range(0, 7);
         hold = D + 6 + $urandom_range(0, 10);
         case (op)
            0, 1, 2: press(1'b1, 1'b0, 1'b0, hold);
            3, 4:    press(1'b0, 1'b1, 1'b0, hold);
            5:       press(1'b1, 1'b1, 1'b0, hold);
            6:       press(1'b0, 1'b1, 1'b1, hold);
            default: bounce($urandom_range(0, 1) == 1, $urandom_range(1, 12), 2 * $urandom_range(1, 5));
         endcase
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
